// File: rtl/rom_stream_pkg.sv
// Shared types and constants for the ROM stream reader slice.
// Optional feature macro used by this slice: ROM_STREAM_LOOP_EN.
package rom_stream_pkg;

    // Sequencer states: idle, issuing ROM reads, waiting for the buffer to empty
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Cycles from driving rom_addr until the word can be written into the buffer
    localparam int ROM_RD_LATENCY = 2;

    // Bits needed to hold a count from 0 to depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// Valid/ready output stream of the ROM stream reader.
// master: the reader (drives data/valid); slave: the consumer (drives ready).
interface rom_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO that absorbs the ROM read pipeline so that
// downstream backpressure never drops a word. Head is shown combinationally.
module rom_stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(FIFO_DEPTH));
    // A pop from a full FIFO frees the slot the same-cycle push lands in
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    // Storage write; entries reset to zero so the head reads 0 out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Address sequencer in front of a 1-cycle synchronous ROM. Reads the
// inclusive range start_addr..end_addr (wrapping modulo 2**ADDR_WIDTH) and
// streams each word out over a valid/ready interface.
// Optional macro ROM_STREAM_LOOP_EN adds a 'loop' input: when set at start,
// the range repeats without a bubble until abort.
module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
`ifdef ROM_STREAM_LOOP_EN
    input  logic                  loop,
`endif
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_q,
    rom_stream_reader_if.master   m,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = count_width(FIFO_DEPTH);
    localparam int OW = CW + 1;
    localparam int LW = count_width(ROM_RD_LATENCY);
    localparam logic [ADDR_WIDTH:0] ONE_WORD = 1;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg;
    logic [ADDR_WIDTH-1:0]   issue_left_reg;   // reads still to issue after the current one
    logic [ADDR_WIDTH:0]     words_left_reg;   // beats not yet handed downstream
    logic [ROM_RD_LATENCY-1:0] pipe_reg;       // marks ROM reads in flight
    logic                    busy_reg;
    logic                    done_reg;

`ifdef ROM_STREAM_LOOP_EN
    logic                    loop_reg;
    logic [ADDR_WIDTH-1:0]   start_addr_reg;
    logic [ADDR_WIDTH-1:0]   span_reg;
`endif

    logic                    loop_active;
    logic [ADDR_WIDTH-1:0]   span;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [LW-1:0]           inflight;
    logic [OW-1:0]           occupancy;
    logic                    credit;
    logic                    start_ok;
    logic                    read_adv;
    logic                    issue;
    logic                    push;
    logic                    beat;

`ifdef ROM_STREAM_LOOP_EN
    assign loop_active = loop_reg;
`else
    assign loop_active = 1'b0;
`endif

    // Distance from start to end; modulo arithmetic handles the wrap case
    assign span = end_addr - start_addr;

    assign beat = !fifo_empty && m.m_ready;
    assign push = pipe_reg[ROM_RD_LATENCY-1] && !abort;

    // Count reads in flight and decide whether another one fits in the buffer
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_RD_LATENCY; i++) begin
            inflight = inflight + LW'(pipe_reg[i]);
        end
        occupancy = OW'(fifo_count) + OW'(inflight);
        credit    = !fifo_full && (occupancy < OW'(FIFO_DEPTH));
        start_ok  = (state_reg == IDLE) && start && !abort;
        read_adv  = (state_reg == READ) && !abort && credit &&
                    ((issue_left_reg != '0) || loop_active);
        issue     = start_ok || read_adv;
    end

    // Read-latency pipe: the tail bit says rom_q holds a word to buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_reg <= '0;
        end else if (abort) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg <= {pipe_reg[ROM_RD_LATENCY-2:0], issue};
        end
    end

    // Sequencer FSM with address counter, word counter and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            rom_addr_reg   <= '0;
            issue_left_reg <= '0;
            words_left_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
`ifdef ROM_STREAM_LOOP_EN
            loop_reg       <= 1'b0;
            start_addr_reg <= '0;
            span_reg       <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            state_reg      <= READ;
                            busy_reg       <= 1'b1;
                            rom_addr_reg   <= start_addr;
                            issue_left_reg <= span;
                            words_left_reg <= {1'b0, span} + ONE_WORD;
`ifdef ROM_STREAM_LOOP_EN
                            loop_reg       <= loop;
                            start_addr_reg <= start_addr;
                            span_reg       <= span;
`endif
                        end
                    end
                    READ: begin
                        if (read_adv) begin
                            if (issue_left_reg != '0) begin
                                rom_addr_reg   <= rom_addr_reg + 1'b1;
                                issue_left_reg <= issue_left_reg - 1'b1;
                            end
`ifdef ROM_STREAM_LOOP_EN
                            else begin
                                // Loop mode: jump straight back to the first address
                                rom_addr_reg   <= start_addr_reg;
                                issue_left_reg <= span_reg;
                            end
`endif
                        end else if ((issue_left_reg == '0) && !loop_active) begin
                            state_reg <= DRAIN;
                        end
                        if (beat) begin
                            words_left_reg <= words_left_reg - 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (beat) begin
                            words_left_reg <= words_left_reg - 1'b1;
                            if (words_left_reg == ONE_WORD) begin
                                state_reg <= IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    rom_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (rom_q),
        .pop       (beat),
        .flush     (abort),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rom_addr  = rom_addr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign m.m_data  = fifo_head;
    assign m.m_valid = !fifo_empty;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM model mem[i] = 8'h10 + i with a
// 1-cycle registered read; expected beats queued at start, popped on handshake.
module tb_rom_stream_reader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_q = '0;
    logic          busy;
    logic          done;
`ifdef ROM_STREAM_LOOP_EN
    logic          loop = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [DW-1:0] exp_q [$];

    rom_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    rom_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .end_addr   (end_addr),
`ifdef ROM_STREAM_LOOP_EN
        .loop       (loop),
`endif
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .m          (s_if),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= 8'h10 + 8'(rom_addr);

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [AW-1:0] s, input logic [AW-1:0] e);
        logic [AW-1:0] a;
        a = s;
        exp_q.push_back(8'h10 + 8'(a));
        while (a != e) begin
            a = a + 1'b1;
            exp_q.push_back(8'h10 + 8'(a));
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (rom_addr !== 4'h0) begin errors++; $display("FAIL reset_rom_addr got %h expected 0", rom_addr); end
        checks++; if (s_if.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %h expected 00", s_if.m_data); end
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b expected 0", s_if.m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        int cyc; int d0; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b1;
        d0 = done_cnt;
        push_range(4'd2, 4'd5);
        start_addr = 4'd2; end_addr = 4'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        checks++; if (rom_addr !== 4'd2) begin errors++; $display("FAIL single_rom_addr got %h expected 2", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy); end
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e0 got %b expected 0", s_if.m_valid); end
        cycle();
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_e1 got %b expected 0", s_if.m_valid); end
        cycle();
        checks++; if (s_if.m_valid !== 1'b1) begin errors++; $display("FAIL single_valid_e2 got %b expected 1", s_if.m_valid); end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL single_data got %h expected %h", s_if.m_data, exp); end
                else $display("single beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        checks++; if (exp_q.size() != 0 || cyc != 4) begin errors++; $display("FAIL single_cycles got %0d cycles/%0d left expected 4/0", cyc, exp_q.size()); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL single_done got done=%b busy=%b expected done=1 busy=0", done, busy); end
        cycle();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b expected 0", done); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        int cyc; int d0; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b1;
        d0 = done_cnt;
        push_range(4'd14, 4'd1);
        checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL wrap_len got %0d expected 4", exp_q.size()); end
        start_addr = 4'd14; end_addr = 4'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL wrap_data got %h expected %h", s_if.m_data, exp); end
                else $display("wrap beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d left expected 0", exp_q.size()); end
        repeat (4) cycle();
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL wrap_done_count got %0d expected 1", done_cnt - d0); end
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL wrap_extra_valid got %b expected 0", s_if.m_valid); end
    endtask

    task automatic test_backpressure();
        int cyc; int beats; int occ; int max_occ; int prev_occ;
        logic prev_stall; logic [DW-1:0] prev_data; logic [AW-1:0] prev_addr; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b0;
        push_range(4'd0, 4'd15);
        start_addr = 4'd0; end_addr = 4'd15; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0; beats = 0; max_occ = 0; prev_occ = 0; prev_stall = 1'b0; prev_data = '0; prev_addr = rom_addr;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (prev_stall) begin
                checks++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== prev_data) begin
                    errors++; $display("FAIL bp_stable got %b/%h expected 1/%h", s_if.m_valid, s_if.m_data, prev_data);
                end
            end
            occ = (int'(rom_addr) + 1) - beats;
            if (occ > max_occ) max_occ = occ;
            checks++; if (occ > DEPTH) begin errors++; $display("FAIL bp_occupancy got %0d expected <= %0d", occ, DEPTH); end
            if (prev_occ == DEPTH) begin
                checks++;
                if (rom_addr !== prev_addr) begin errors++; $display("FAIL bp_addr_stall got %h expected %h", rom_addr, prev_addr); end
            end
            s_if.m_ready = (cyc % 3 == 0);
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                beats++;
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL bp_data got %h expected %h", s_if.m_data, exp); end
                else $display("backpressure beat %h", s_if.m_data);
            end
            prev_stall = (s_if.m_valid === 1'b1) && !s_if.m_ready;
            prev_data  = s_if.m_data;
            prev_occ   = occ;
            prev_addr  = rom_addr;
            cycle();
            cyc++;
        end
        checks++; if (beats != 16) begin errors++; $display("FAIL bp_beats got %0d expected 16", beats); end
        checks++; if (max_occ != DEPTH) begin errors++; $display("FAIL bp_full_reached got %0d expected %0d", max_occ, DEPTH); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b expected 1", done); end
        s_if.m_ready = 1'b1;
        cycle();
    endtask

    task automatic test_abort();
        int cyc; int beats; int d0; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b1;
        d0 = done_cnt;
        push_range(4'd0, 4'd15);
        start_addr = 4'd0; end_addr = 4'd15; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0; beats = 0;
        while (beats < 3 && cyc < 50) begin
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                beats++;
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL abort_data got %h expected %h", s_if.m_data, exp); end
                else $display("abort-run beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b expected 0", s_if.m_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
        repeat (3) cycle();
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL abort_inflight got %b expected 0", s_if.m_valid); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d expected 0", done_cnt - d0); end
        exp_q.delete();
        push_range(4'd0, 4'd0);
        start_addr = 4'd0; end_addr = 4'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0; beats = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                beats++;
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL restart_data got %h expected %h", s_if.m_data, exp); end
                else $display("restart beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        repeat (3) cycle();
        checks++; if (beats != 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL restart_single got beats=%0d done=%0d expected 1/1", beats, done_cnt - d0); end
    endtask

    task automatic test_start_busy();
        int cyc; int d0; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b1;
        d0 = done_cnt;
        push_range(4'd4, 4'd7);
        start_addr = 4'd4; end_addr = 4'd7; start = 1'b1;
        cycle();
        start_addr = 4'd9; end_addr = 4'd9;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            start = (cyc < 2);
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                exp = exp_q.pop_front();
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL busy_start_data got %h expected %h", s_if.m_data, exp); end
                else $display("busy-start beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        start = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_timeout got %0d left expected 0", exp_q.size()); end
        repeat (3) cycle();
        checks++; if (s_if.m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_extra got valid=%b busy=%b expected 0/0", s_if.m_valid, busy); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_async_reset();
        exp_q.delete();
        s_if.m_ready = 1'b0;
        start_addr = 4'd0; end_addr = 4'd15; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        checks++; if (s_if.m_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL arst_pre got valid=%b busy=%b expected 1/1", s_if.m_valid, busy); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (rom_addr !== 4'h0) begin errors++; $display("FAIL arst_rom_addr got %h expected 0", rom_addr); end
        checks++; if (s_if.m_data !== 8'h00) begin errors++; $display("FAIL arst_m_data got %h expected 00", s_if.m_data); end
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL arst_m_valid got %b expected 0", s_if.m_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_status got busy=%b done=%b expected 0/0", busy, done); end
        #3;
        rst_n = 1'b1;
        s_if.m_ready = 1'b1;
        cycle();
        checks++; if (busy !== 1'b0 || s_if.m_valid !== 1'b0) begin errors++; $display("FAIL arst_idle got busy=%b valid=%b expected 0/0", busy, s_if.m_valid); end
    endtask

`ifdef ROM_STREAM_LOOP_EN
    task automatic test_loop();
        int cyc; int beats; int d0; int first; logic [DW-1:0] exp;
        exp_q.delete();
        s_if.m_ready = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) push_range(4'd3, 4'd4);
        loop = 1'b1; start_addr = 4'd3; end_addr = 4'd4; start = 1'b1;
        cycle();
        start = 1'b0;
        cyc = 0; beats = 0; first = -1;
        while (exp_q.size() > 0 && cyc < 80) begin
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                if (first < 0) first = cyc;
                exp = exp_q.pop_front();
                beats++;
                checks++;
                if (s_if.m_data !== exp) begin errors++; $display("FAIL loop_data got %h expected %h", s_if.m_data, exp); end
                else $display("loop beat %h", s_if.m_data);
            end
            cycle();
            cyc++;
        end
        checks++; if (beats != 10 || cyc - first != 10) begin errors++; $display("FAIL loop_rate got beats=%0d cycles=%0d expected 10/10", beats, cyc - first); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b expected 1", busy); end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        loop = 1'b0;
        checks++; if (busy !== 1'b0 || s_if.m_valid !== 1'b0) begin errors++; $display("FAIL loop_abort got busy=%b valid=%b expected 0/0", busy, s_if.m_valid); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL loop_no_done got %0d expected 0", done_cnt - d0); end
    endtask
`endif

    initial begin
        s_if.m_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_abort();
        test_start_busy();
        test_async_reset();
`ifdef ROM_STREAM_LOOP_EN
        test_loop();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
